// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the MIPS IF stage: reset fetch address, fetch FSM
// state encodings and the NOP word that fills an empty IF/ID register.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_BLOCK = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave). At most one request outstanding.
interface fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              Imem_req;
   logic [ADDR_W-1:0] Imem_addr;
   logic              Imem_ack;
   logic [31:0]       Imem_data;

   modport master (
      output Imem_req,
      output Imem_addr,
      input  Imem_ack,
      input  Imem_data
   );

   modport slave (
      input  Imem_req,
      input  Imem_addr,
      output Imem_ack,
      output Imem_data
   );
endinterface

// File: rtl/fetch_unit_skid.sv
// One-entry {instr, pc} skid buffer holding a fetch response that arrived
// while the IF/ID register was stalled.
module fetch_skid #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_i,
   input  logic              rd_i,
   input  logic [31:0]       instr_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              full_o,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] pc_o
);

   logic              full_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
      end else if (wr_i) begin
         full_q <= 1'b1;
      end else if (rd_i) begin
         full_q <= 1'b0;
      end
   end

   // Payload is qualified by full_q, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (wr_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC, instruction fetch, IF/ID register and delay-slot redirect.
// Define FETCH_ALIGN_CHECK_EN to add the sticky Addr_err misaligned-target flag.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              Stall,
   input  logic              Taken,
   input  logic [ADDR_W-1:0] Target,
   fetch_unit_if.master      imem,
   output logic              Instr_valid,
   output logic [31:0]       Instr_out,
   output logic [ADDR_W-1:0] PC_out,
   output logic [ADDR_W-1:0] PC4_out
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic              Addr_err
`endif
);

   fetch_state_e      state_q;
   logic              req_q;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              redir_pend_q, redir_pend_d;
   logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
   logic              valid_q, valid_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pc4_q, pc4_d;

   logic              ack_acc, ifid_free, br_acc;
   logic              skid_wr, skid_rd, skid_full;
   logic [31:0]       skid_instr;
   logic [ADDR_W-1:0] skid_pc, target_w;

   assign ack_acc   = (state_q == ST_REQ) && imem.Imem_ack;
   assign ifid_free = !valid_q || !Stall;
   assign br_acc    = valid_q && !Stall && Taken;
   assign skid_wr   = ack_acc && !ifid_free;
   assign skid_rd   = (state_q == ST_BLOCK) && !Stall;
   assign target_w  = Target & {{(ADDR_W-2){1'b1}}, 2'b00};

   fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .wr_i    (skid_wr),
      .rd_i    (skid_rd),
      .instr_i (imem.Imem_data),
      .pc_i    (fetch_pc_q),
      .full_o  (skid_full),
      .instr_o (skid_instr),
      .pc_o    (skid_pc)
   );

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      pc4_d        = pc4_q;

      // The acked word is the delay slot whenever a branch is in ID, so the
      // target applies to the very next fetch address.
      if (ack_acc) begin
         if (br_acc)            fetch_pc_d = target_w;
         else if (redir_pend_q) fetch_pc_d = redir_pc_q;
         else                   fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         redir_pend_d = 1'b0;
      end else if (br_acc) begin
         if (state_q == ST_BLOCK) begin
            // Delay slot already sits in the skid; fetch_pc is not yet issued.
            fetch_pc_d = target_w;
         end else begin
            redir_pend_d = 1'b1;
            redir_pc_d   = target_w;
         end
      end

      if (ifid_free) begin
         if (skid_full) begin
            valid_d = 1'b1;
            instr_d = skid_instr;
            pc_d    = skid_pc;
            pc4_d   = skid_pc + ADDR_W'(4);
         end else if (ack_acc) begin
            valid_d = 1'b1;
            instr_d = imem.Imem_data;
            pc_d    = fetch_pc_q;
            pc4_d   = fetch_pc_q + ADDR_W'(4);
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_REQ;
               req_q   <= 1'b1;
            end
            ST_REQ: begin
               if (skid_wr) begin
                  state_q <= ST_BLOCK;
                  req_q   <= 1'b0;
               end
            end
            ST_BLOCK: begin
               if (!Stall) begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         fetch_pc_q   <= RESET_PC;
         redir_pend_q <= 1'b0;
         valid_q      <= 1'b0;
         instr_q      <= NOP_INSTR;
         pc_q         <= '0;
         pc4_q        <= ADDR_W'(4);
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         redir_pend_q <= redir_pend_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         pc4_q        <= pc4_d;
      end
   end

   always_ff @(posedge CLK) begin
      redir_pc_q <= redir_pc_d;
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic addr_err_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         addr_err_q <= 1'b0;
      end else if (br_acc && (Target[1:0] != 2'b00)) begin
         addr_err_q <= 1'b1;
      end
   end

   assign Addr_err = addr_err_q;
`endif

   assign imem.Imem_req  = req_q;
   assign imem.Imem_addr = fetch_pc_q;
   assign Instr_valid    = valid_q;
   assign Instr_out      = instr_q;
   assign PC_out         = pc_q;
   assign PC4_out        = pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and delivered
// instructions are queued by the stimulus and checked by a negedge monitor.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        Stall;
   logic        Taken;
   logic [31:0] Target;
   logic        Instr_valid;
   logic [31:0] Instr_out;
   logic [31:0] PC_out;
   logic [31:0] PC4_out;
   logic        ack_en;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        Addr_err;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_fpop   = 0;
   int          n_dpop   = 0;
   logic [31:0] fq[$];
   logic [31:0] dq[$];

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   fetch_unit_if bus ();

   assign bus.Imem_ack  = ack_en & bus.Imem_req;
   assign bus.Imem_data = mem_f(bus.Imem_addr);

   fetch_unit dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .Stall       (Stall),
      .Taken       (Taken),
      .Target      (Target),
      .imem        (bus),
      .Instr_valid (Instr_valid),
      .Instr_out   (Instr_out),
      .PC_out      (PC_out),
      .PC4_out     (PC4_out)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .Addr_err    (Addr_err)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         fq.push_back(start + 32'(4 * i));
         dq.push_back(start + 32'(4 * i));
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_valid"}, 32'(Instr_valid), 32'd0);
      check({tag, "_instr"}, Instr_out, 32'h0000_0000);
      check({tag, "_pc"}, PC_out, 32'h0000_0000);
      check({tag, "_pc4"}, PC4_out, 32'h0000_0004);
      check({tag, "_req"}, 32'(bus.Imem_req), 32'd0);
      check({tag, "_addr"}, bus.Imem_addr, 32'h0040_0000);
   endtask

   task automatic wait_pc(input logic [31:0] pc);
      for (int i = 0; i < 200; i++) begin
         @(posedge CLK);
         #1;
         if (Instr_valid && PC_out == pc) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_pc: PC_out %h never reached %h", PC_out, pc);
   endtask

   // Monitor: every accepted fetch and every instruction consumed by ID.
   always @(negedge CLK) begin : monitor
      logic [31:0] e;
      if (RESET) begin
         if (bus.Imem_req && bus.Imem_ack) begin
            if (fq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL fetch_extra: fetch of %h, none expected", bus.Imem_addr);
            end else begin
               e = fq.pop_front();
               n_fpop++;
               check("fetch_addr", bus.Imem_addr, e);
            end
         end
         if (Instr_valid && !Stall) begin
            if (dq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL deliver_extra: PC_out %h delivered, none expected", PC_out);
            end else begin
               e = dq.pop_front();
               n_dpop++;
               check("deliver_pc", PC_out, e);
               check("deliver_instr", Instr_out, mem_f(e));
               check("deliver_pc4", PC4_out, e + 32'd4);
            end
         end
      end
   end

   initial begin
      RESET  = 1'b1;
      Stall  = 1'b0;
      Taken  = 1'b0;
      Target = 32'h0;
      ack_en = 1'b1;
      #2 RESET = 1'b0;
      #1 check_reset("reset0");

      push_seq(32'h0040_0000, 6);
      push_seq(32'h0040_0100, 3);
      push_seq(32'h0040_0200, 40);

      @(negedge CLK);
      #2 RESET = 1'b1;
      #1 check("idle_req", 32'(bus.Imem_req), 32'd0);
      @(posedge CLK);
      #1;
      check("first_req", 32'(bus.Imem_req), 32'd1);
      check("first_addr", bus.Imem_addr, 32'h0040_0000);
      check("first_valid_low", 32'(Instr_valid), 32'd0);
      @(posedge CLK);
      #1;
      check("valid_rise", 32'(Instr_valid), 32'd1);
      check("valid_rise_pc", PC_out, 32'h0040_0000);
      check("second_addr", bus.Imem_addr, 32'h0040_0004);

      // Branch at 0x10 while the delay-slot fetch is still outstanding.
      wait_pc(32'h0040_0010);
      ack_en = 1'b0;
      Taken  = 1'b1;
      Target = 32'h0040_0100;
      @(posedge CLK);
      #1;
      Taken  = 1'b0;
      ack_en = 1'b1;
      check("br1_bubble", 32'(Instr_valid), 32'd0);
      check("br1_slot_addr", bus.Imem_addr, 32'h0040_0014);
      @(posedge CLK);
      #1;
      check("br1_slot_pc", PC_out, 32'h0040_0014);
      check("br1_target_addr", bus.Imem_addr, 32'h0040_0100);

      // Branch at 0x104 in the same cycle as the delay-slot ack.
      wait_pc(32'h0040_0104);
      Taken  = 1'b1;
      Target = 32'h0040_0200;
      @(posedge CLK);
      #1;
      Taken = 1'b0;
      check("br2_slot_pc", PC_out, 32'h0040_0108);
      check("br2_target_addr", bus.Imem_addr, 32'h0040_0200);

      // Three-cycle stall with an ack landing in the skid.
      wait_pc(32'h0040_0208);
      Stall = 1'b1;
      @(posedge CLK);
      #1;
      repeat (2) begin
         @(negedge CLK);
         check("stall_req", 32'(bus.Imem_req), 32'd0);
         check("stall_pc", PC_out, 32'h0040_0208);
         check("stall_instr", Instr_out, mem_f(32'h0040_0208));
      end
      @(posedge CLK);
      #1;
      Stall = 1'b0;

      // Reset mid-run with the skid full.
      wait_pc(32'h0040_0218);
      Stall = 1'b1;
      @(posedge CLK);
      #1;
      check("pre_reset_block", 32'(bus.Imem_req), 32'd0);
      #2 RESET = 1'b0;
      #1 check_reset("reset1");
      fq.delete();
      dq.delete();
      n_fpop = 0;
      n_dpop = 0;
      Stall  = 1'b0;
      push_seq(32'h0040_0000, 4);
      push_seq(32'h0040_0100, 10);
      @(negedge CLK);
      @(negedge CLK);
      #2 RESET = 1'b1;
      #1 check("idle_req2", 32'(bus.Imem_req), 32'd0);
      @(posedge CLK);
      #1;
      check("restart_req", 32'(bus.Imem_req), 32'd1);
      check("restart_addr", bus.Imem_addr, 32'h0040_0000);

      // Misaligned target: low bits dropped, flagged when the check is built in.
      wait_pc(32'h0040_0008);
`ifdef FETCH_ALIGN_CHECK_EN
      check("addr_err_clear", 32'(Addr_err), 32'd0);
`endif
      Taken  = 1'b1;
      Target = 32'h0040_0102;
      @(posedge CLK);
      #1;
      Taken = 1'b0;
      check("br3_slot_pc", PC_out, 32'h0040_000C);
      check("br3_target_addr", bus.Imem_addr, 32'h0040_0100);
`ifdef FETCH_ALIGN_CHECK_EN
      check("addr_err_set", 32'(Addr_err), 32'd1);
`endif

      wait_pc(32'h0040_0108);
      ack_en = 1'b0;
      begin : drain
         for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (!Instr_valid) disable drain;
         end
      end
      check("drain_valid", 32'(Instr_valid), 32'd0);
      check("run2_fetch_count", 32'(n_fpop), 32'd7);
      check("run2_deliver_count", 32'(n_dpop), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
